serial_compare_ctrl: RTL and testbench
======================================

# serial_compare_ctrl

Sequencer that performs a multi-bit magnitude comparison by stepping a single-bit greater/equal/lesser comparator cell across two latched operands, MSB first, one bit per clock. It terminates early at the first differing bit and reports one-hot greater/equal/lesser flags with a start/done handshake. It sits between a requesting datapath and the team's 1-bit comparator cell, and scales that cell to WIDTH-bit unsigned or two's-complement operands without a full parallel comparator.

## Interface
- WIDTH, 8, operand width in bits; must be at least 2.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  comparison request; sampled only in IDLE.
- a  input  WIDTH  operand A; latched on an accepted start.
- b  input  WIDTH  operand B; latched on an accepted start.
- signed_mode  input  1  0 = unsigned, 1 = two's complement; latched on an accepted start.
- busy  output  1  high in SCAN and DONE.
- done  output  1  one-cycle pulse when the result is valid.
- greater  output  1  result A > B.
- equal  output  1  result A == B.
- lesser  output  1  result A < B.
- bits_used  output  clog2(WIDTH+1)  number of bit positions examined in the last comparison.

## Operation
- States:
  - IDLE: wait for start.
  - SCAN: compare one bit per cycle.
  - DONE: done=1 for one cycle, then IDLE.
- IDLE to SCAN on start=1:
  - latch a, b and signed_mode into internal registers;
  - set idx = WIDTH-1;
  - clear greater, equal, lesser to 0.
- Each SCAN cycle evaluates the latched bits a_r[idx] and b_r[idx] with the 1-bit comparator.
- Sign bit in signed_mode: at idx = WIDTH-1 the greater and lesser roles are swapped. a_r=0 with b_r=1 means A > B.
- SCAN exit on a differing bit:
  - register greater or lesser;
  - set bits_used = WIDTH-idx;
  - go to DONE.
- SCAN exit on equal bits with idx = 0:
  - register equal=1;
  - set bits_used = WIDTH;
  - go to DONE.
- SCAN on equal bits with idx > 0: decrement idx and stay in SCAN.
- Start handling:
  - start is ignored in SCAN and DONE;
  - it is not queued;
  - a, b and signed_mode changing during SCAN have no effect.
- Result hold: greater, equal, lesser and bits_used keep their value until the next accepted start.
- After the first completion exactly one of greater, equal, lesser is high.

## Timing
- Reset:
  - state = IDLE;
  - busy = 0, done = 0;
  - greater = equal = lesser = 0;
  - bits_used = 0;
  - idx = WIDTH-1.
- Reset mid-SCAN or mid-DONE aborts the operation: no done pulse and flags cleared.
- Reset has priority over start in the same cycle.
- Edge E is the edge that samples start=1 in IDLE.
  - busy = 1 from E.
  - The comparison result registers at edge E+k, where k is the number of bits examined (1..WIDTH).
  - done = 1 during the cycle after E+k; busy stays 1 during that cycle.
  - At E+k+1, busy = 0 and done = 0.
- Latency from start to done pulse:
  - minimum 1 cycle, when the MSB differs;
  - maximum WIDTH cycles, when the operands are equal.
- A start held high continuously is accepted again in the first IDLE cycle. That is one idle cycle after done, giving back-to-back throughput of k+2 cycles.
- Outputs are all registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then start with a=0x80, b=0x7F, signed_mode=0, WIDTH=8:
  - done pulses one cycle after busy rises;
  - greater=1 and bits_used=1.
- Same operands with signed_mode=1:
  - lesser=1 and bits_used=1, because -128 < 127.
- a=b=0xA5:
  - done pulses 8 cycles after E;
  - equal=1 and bits_used=8;
  - busy is high for 9 cycles.
- a=0x10, b=0x18, then change a and b and pulse start while busy:
  - the result is lesser=1 with bits_used=5;
  - the second start is ignored, so there is exactly one done pulse.
- Assert rst during the 3rd SCAN cycle of a=b=0xFF:
  - next cycle busy=0, done=0 and all flags=0;
  - no done pulse follows.
- Exhaustive sweep at WIDTH=4, all 256 (a,b) pairs in both modes with start held high:
  - flags match a reference compare every time;
  - flags are always one-hot;
  - the spacing between done pulses equals bits_used+2.

Source files
------------

// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl
//   Multi-bit magnitude comparator built by stepping a 1-bit greater/equal/
//   lesser cell across two latched operands, MSB first, one bit per clock.
//   Stops at the first differing bit and reports one-hot result flags.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        comparison request, sampled only in IDLE
//   a, b         WIDTH-bit operands, latched on an accepted start
//   signed_mode  0 = unsigned, 1 = two's complement (latched on start)
//   busy         high while scanning and during the done cycle
//   done         one-cycle pulse when the result is valid
//   greater      A > B
//   equal        A == B
//   lesser       A < B
//   bits_used    number of bit positions examined by the last comparison
module serial_compare_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  input  logic                         signed_mode,
  output logic                         busy,
  output logic                         done,
  output logic                         greater,
  output logic                         equal,
  output logic                         lesser,
  output logic [$clog2(WIDTH+1)-1:0]   bits_used
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned BW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             signed_q, signed_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             greater_q, greater_d;
  logic             equal_q, equal_d;
  logic             lesser_q, lesser_d;
  logic [BW-1:0]    bits_used_q, bits_used_d;

  // 1-bit comparator cell outputs for the current position
  logic a_bit, b_bit;
  logic cell_gt, cell_lt;
  logic bit_gt, bit_lt;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    signed_d    = signed_q;
    idx_d       = idx_q;
    greater_d   = greater_q;
    equal_d     = equal_q;
    lesser_d    = lesser_q;
    bits_used_d = bits_used_q;

    a_bit   = a_q[idx_q];
    b_bit   = b_q[idx_q];
    cell_gt = a_bit & ~b_bit;
    cell_lt = ~a_bit & b_bit;
    // In two's complement the sign bit carries negative weight, so a set
    // sign bit makes the operand smaller: swap the cell's roles there.
    if (signed_q && (idx_q == IW'(WIDTH - 1))) begin
      bit_gt = cell_lt;
      bit_lt = cell_gt;
    end else begin
      bit_gt = cell_gt;
      bit_lt = cell_lt;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SCAN;
          a_d       = a;
          b_d       = b;
          signed_d  = signed_mode;
          idx_d     = IW'(WIDTH - 1);
          greater_d = 1'b0;
          equal_d   = 1'b0;
          lesser_d  = 1'b0;
        end
      end
      S_SCAN: begin
        if (bit_gt || bit_lt) begin
          greater_d   = bit_gt;
          lesser_d    = bit_lt;
          bits_used_d = BW'(WIDTH - 32'(idx_q));
          state_d     = S_DONE;
        end else if (idx_q == '0) begin
          equal_d     = 1'b1;
          bits_used_d = BW'(WIDTH);
          state_d     = S_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake outputs are registered copies of the next-state decode.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      signed_q    <= 1'b0;
      idx_q       <= IW'(WIDTH - 1);
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      greater_q   <= 1'b0;
      equal_q     <= 1'b0;
      lesser_q    <= 1'b0;
      bits_used_q <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      signed_q    <= signed_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      greater_q   <= greater_d;
      equal_q     <= equal_d;
      lesser_q    <= lesser_d;
      bits_used_q <= bits_used_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign greater   = greater_q;
  assign equal     = equal_q;
  assign lesser    = lesser_q;
  assign bits_used = bits_used_q;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Testbench for serial_compare_ctrl: directed WIDTH=8 cases plus an
// exhaustive WIDTH=4 sweep with start held high.
module tb_serial_compare_ctrl;

  typedef struct {
    bit g;
    bit e;
    bit l;
    int bits;
    int ecyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // WIDTH = 8 instance
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       sm8 = 1'b0;
  logic       busy8, done8, g8, e8, l8;
  logic [3:0] bu8;

  // WIDTH = 4 instance
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       sm4 = 1'b0;
  logic       busy4, done4, g4, e4, l4;
  logic [2:0] bu4;

  serial_compare_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .signed_mode(sm8), .busy(busy8), .done(done8),
    .greater(g8), .equal(e8), .lesser(l8), .bits_used(bu8)
  );

  serial_compare_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .signed_mode(sm4), .busy(busy4), .done(done4),
    .greater(g4), .equal(e4), .lesser(l4), .bits_used(bu4)
  );

  exp_t q8[$];
  exp_t q4[$];
  int   ndone8 = 0;
  int   prev4 = 0;
  bit   have_prev4 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: numeric compare plus position of the most significant
  // differing bit.
  function automatic exp_t model(input int w, input int av, input int bv, input bit sm);
    exp_t r;
    int   sa, sb, x;
    bit   found;
    sa = av;
    sb = bv;
    if (sm) begin
      if (av >= (1 << (w - 1))) sa = av - (1 << w);
      if (bv >= (1 << (w - 1))) sb = bv - (1 << w);
    end
    r.g = (sa > sb);
    r.e = (sa == sb);
    r.l = (sa < sb);
    x = av ^ bv;
    r.bits = w;
    found = 1'b0;
    for (int i = w - 1; i >= 0; i--) begin
      if (!found && x[i]) begin
        r.bits = w - i;
        found = 1'b1;
      end
    end
    r.ecyc = 0;
    return r;
  endfunction

  always @(negedge clk) begin
    if (done8) begin
      exp_t e;
      ndone8++;
      if (q8.size() == 0) begin
        chk("sb8_unexpected_done", 1, 0);
      end else begin
        e = q8.pop_front();
        chk("g8", g8, e.g);
        chk("e8", e8, e.e);
        chk("l8", l8, e.l);
        chk("bits8", bu8, e.bits);
        chk("latency8", cyc - e.ecyc, e.bits);
      end
    end
  end

  always @(negedge clk) begin
    if (done4) begin
      exp_t e;
      if (q4.size() == 0) begin
        chk("sb4_unexpected_done", 1, 0);
      end else begin
        e = q4.pop_front();
        chk("g4", g4, e.g);
        chk("e4", e4, e.e);
        chk("l4", l4, e.l);
        chk("bits4", bu4, e.bits);
        chk("onehot4", $onehot({g4, e4, l4}), 1);
        if (have_prev4) chk("spacing4", cyc - prev4, e.bits + 2);
      end
      prev4 = cyc;
      have_prev4 = 1'b1;
    end
  end

  // One comparison on the 8-bit instance; optionally disturbs operands and
  // pulses start while busy (must be ignored).
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input bit sm, input bit disturb);
    exp_t e;
    int   nd0, nbusy, guard;
    nd0 = ndone8;
    @(negedge clk);
    a8 = av; b8 = bv; sm8 = sm; start8 = 1'b1;
    e = model(8, int'(av), int'(bv), sm);
    @(posedge clk);
    #1;
    e.ecyc = cyc;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    nbusy = 0;
    guard = 0;
    while (busy8 && guard < 40) begin
      nbusy++;
      if (disturb && nbusy == 2) begin
        a8 = 8'hFF; b8 = 8'h00; sm8 = 1'b1; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    start8 = 1'b0;
    chk("timeout8", guard < 40, 1);
    chk("busy_cycles8", nbusy, e.bits + 1);
    repeat (4) @(negedge clk);
    chk("done_count8", ndone8 - nd0, 1);
    chk("hold_g8", g8, e.g);
    chk("hold_e8", e8, e.e);
    chk("hold_l8", l8, e.l);
    chk("hold_bits8", bu8, e.bits);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd0, guard;
    exp_t e;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_flags", {g8, e8, l8}, 0);
    chk("rst_bits", bu8, 0);
    chk("rst_busy4", busy4, 0);

    run8(8'h80, 8'h7F, 1'b0, 1'b0);
    run8(8'h80, 8'h7F, 1'b1, 1'b0);
    run8(8'hA5, 8'hA5, 1'b0, 1'b0);
    run8(8'h10, 8'h18, 1'b0, 1'b1);
    run8(8'h7F, 8'h80, 1'b1, 1'b0);
    run8(8'hFE, 8'hFF, 1'b1, 1'b0);

    // Reset during the third SCAN cycle aborts the comparison.
    nd0 = ndone8;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; sm8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_flags", {g8, e8, l8}, 0);
    chk("abort_bits", bu8, 0);
    repeat (12) @(negedge clk);
    chk("abort_no_done", ndone8 - nd0, 0);

    // Exhaustive WIDTH=4 sweep, start held high.
    for (int m = 0; m < 2; m++) begin
      for (int ai = 0; ai < 16; ai++) begin
        for (int bi = 0; bi < 16; bi++) begin
          guard = 0;
          while (busy4 && guard < 20) begin
            @(negedge clk);
            guard++;
          end
          if (guard >= 20) chk("timeout4", 0, 1);
          a4 = 4'(ai); b4 = 4'(bi); sm4 = (m != 0); start4 = 1'b1;
          e = model(4, ai, bi, m != 0);
          q4.push_back(e);
          @(negedge clk);
        end
      end
    end
    guard = 0;
    while (busy4 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    start4 = 1'b0;
    repeat (4) @(negedge clk);
    chk("sb4_drained", q4.size(), 0);
    chk("sb8_drained", q8.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
